// File: rtl/custom2axi_if.sv
// AXI4 master-side bus bundle used by the custom2axi bridge.
//
// Carries the five AXI4 channels (AW, W, B, AR, R) for a single-beat,
// 32-bit data / 32-bit address master with 4-bit IDs.
//   master modport : bridge side, drives valids/payloads, bready/rready
//   slave modport  : interconnect/slave side, drives readies and responses
interface custom2axi_if;

    // Write address channel
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [2:0]  awprot;

    // Write data channel
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    // Write response channel
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    // Read address channel
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arprot;

    // Read data channel
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, awprot,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, arprot,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awprot,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, arprot,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

endinterface

// File: rtl/custom2axi.sv
// Native (PicoRV32-style valid/ready) memory bus to AXI4 master bridge.
//
// One single-beat 32-bit transaction is in flight at a time. The request is
// latched in IDLE, so the native side may change mem_* freely afterwards.
// Completion is a one-cycle registered mem_ready pulse; mem_err flags an
// SLVERR/DECERR response and mem_rdata holds the most recent read word.
//
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   mem_valid    : native request valid
//   mem_instr    : request is an instruction fetch (drives AxPROT[2])
//   mem_addr     : byte address
//   mem_wdata    : write data
//   mem_wstrb    : byte strobes, all-zero means read
//   mem_ready    : one-cycle completion pulse
//   mem_rdata    : read data, valid while mem_ready=1, held otherwise
//   mem_err      : response was SLVERR/DECERR, valid while mem_ready=1
//   m_axi        : AXI4 master channels (AW, W, B, AR, R)
//
// Parameters:
//   AXI_ID       : constant driven on awid/arid
//   ALIGN_ADDR   : force awaddr/araddr[1:0] to zero when set
module custom2axi #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter bit         ALIGN_ADDR = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,

    input  logic         mem_valid,
    input  logic         mem_instr,
    output logic         mem_ready,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_wstrb,
    output logic [31:0]  mem_rdata,
    output logic         mem_err,

    custom2axi_if.master m_axi
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } state_e;

    state_e      state_q;

    // Latched request
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    // Registered channel valids and native-side outputs
    logic        awvalid_q;
    logic        wvalid_q;
    logic        arvalid_q;
    logic        mem_ready_q;
    logic        mem_err_q;
    logic [31:0] mem_rdata_q;

    logic [31:0] req_addr;
    logic        aw_fire;
    logic        w_fire;
    logic        ar_fire;
    logic        b_fire;
    logic        r_fire;
    logic        aw_settled;
    logic        w_settled;

    assign req_addr = ALIGN_ADDR ? {mem_addr[31:2], 2'b00} : mem_addr;

    assign aw_fire = awvalid_q && m_axi.awready;
    assign w_fire  = wvalid_q && m_axi.wready;
    assign ar_fire = arvalid_q && m_axi.arready;
    assign b_fire  = m_axi.bvalid && m_axi.bready;
    assign r_fire  = m_axi.rvalid && m_axi.rready;

    // A write channel is settled once it has handshaken, either on an earlier
    // edge (valid already dropped) or on the coming edge.
    assign aw_settled = !awvalid_q || m_axi.awready;
    assign w_settled  = !wvalid_q || m_axi.wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            instr_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_valid && !mem_ready_q) begin
                        addr_q  <= req_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        instr_q <= mem_instr;
                        if (mem_wstrb != 4'd0) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrite;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRaddr;
                        end
                    end
                end

                StWrite: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_settled && w_settled) begin
                        state_q <= StWresp;
                    end
                end

                StWresp: begin
                    if (b_fire) begin
                        mem_ready_q <= 1'b1;
                        mem_err_q   <= m_axi.bresp[1];
                        state_q     <= StDone;
                    end
                end

                StRaddr: begin
                    if (ar_fire) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StRdata;
                    end
                end

                StRdata: begin
                    if (r_fire) begin
                        mem_rdata_q <= m_axi.rdata;
                        mem_err_q   <= m_axi.rresp[1];
                        mem_ready_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end

                StDone: begin
                    // mem_valid is still high here for the request that just
                    // completed; skipping IDLE for one edge avoids re-issuing it.
                    mem_ready_q <= 1'b0;
                    mem_err_q   <= 1'b0;
                    state_q     <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Native-side outputs
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;

    // AW channel
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awid    = AXI_ID;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = 3'd2;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awprot  = {instr_q, 2'b00};

    // W channel
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wlast   = 1'b1;

    // Responses are only accepted in the state that waits for them.
    assign m_axi.bready  = (state_q == StWresp);
    assign m_axi.rready  = (state_q == StRdata);

    // AR channel
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arid    = AXI_ID;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = 3'd2;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arprot  = {instr_q, 2'b00};

    // IDs, RLAST and the low response bit carry nothing this bridge needs.
    logic unused_axi_inputs;
    assign unused_axi_inputs = ^{m_axi.bid, m_axi.rid, m_axi.rlast,
                                 m_axi.bresp[0], m_axi.rresp[0]};

endmodule

// File: tb/tb_custom2axi.sv
// Bench for custom2axi: a delay-programmable AXI slave with its own memory,
// a word-level reference memory updated from native requests, directed
// scenarios and a randomized transaction loop.
module tb_custom2axi;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_err;

    custom2axi_if m_axi ();

    custom2axi #(
        .AXI_ID     (4'd0),
        .ALIGN_ADDR (1'b1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .m_axi     (m_axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave knobs, set per transaction by the main thread
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  cur_resp;

    // Slave bookkeeping
    bit          aw_seen, w_seen, ar_seen, aw_done, w_done, ar_done;
    bit          b_pend, r_pend, b_drop, r_drop;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, ar_total, aw_hi, w_hi;
    logic [34:0] hold_aw, hold_ar;
    logic [35:0] hold_w;
    logic [31:0] cap_awaddr, cap_araddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_awprot, cap_arprot;
    logic [31:0] slave_mem [64];

    // Reference model
    logic [31:0] ref_mem [64];
    logic [31:0] ref_last_rdata;

    localparam logic [16:0] AX_CONST = {4'd0, 8'd0, 3'd2, 2'b01};

    task automatic slave_idle();
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        m_axi.arready = 1'b0;
        m_axi.bvalid  = 1'b0;
        m_axi.bresp   = 2'b00;
        m_axi.bid     = 4'd0;
        m_axi.rvalid  = 1'b0;
        m_axi.rdata   = 32'd0;
        m_axi.rresp   = 2'b00;
        m_axi.rlast   = 1'b0;
        m_axi.rid     = 4'd0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        b_pend = 0; r_pend = 0; b_drop = 0; r_drop = 0;
    endtask

    // AXI slave: decides all of its outputs at the negedge, so a handshake at
    // the following posedge is exactly valid && ready as seen here.
    initial begin
        slave_idle();
        forever begin
            @(negedge clk);
            if (!resetn) begin
                slave_idle();
            end else begin
                if (b_drop) begin m_axi.bvalid = 1'b0; b_drop = 0; end
                if (r_drop) begin m_axi.rvalid = 1'b0; r_drop = 0; end

                // B: only after both AW and W handshakes have happened
                if (aw_done && w_done && !b_pend && !m_axi.bvalid && !b_drop) begin
                    b_pend = 1; b_wait = b_dly;
                end
                if (b_pend) begin
                    if (b_wait == 0) begin
                        m_axi.bvalid = 1'b1; m_axi.bresp = cur_resp;
                        m_axi.bid = 4'($urandom); b_pend = 0;
                    end else b_wait--;
                end
                if (m_axi.bready)
                    check_eq("bready_after_aw_w", 64'({aw_done, w_done}), 64'(2'b11));
                if (m_axi.bvalid && m_axi.bready) begin
                    b_cnt++; b_drop = 1; aw_done = 0; w_done = 0;
                    if (!cur_resp[1])
                        for (int b = 0; b < 4; b++)
                            if (cap_wstrb[b])
                                slave_mem[cap_awaddr[7:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                end

                // R: only after the AR handshake
                if (ar_done && !r_pend && !m_axi.rvalid && !r_drop) begin
                    r_pend = 1; r_wait = r_dly;
                end
                if (r_pend) begin
                    if (r_wait == 0) begin
                        m_axi.rvalid = 1'b1; m_axi.rresp = cur_resp;
                        m_axi.rdata = slave_mem[cap_araddr[7:2]];
                        m_axi.rlast = 1'b1; m_axi.rid = 4'($urandom); r_pend = 0;
                    end else r_wait--;
                end
                if (m_axi.rready)
                    check_eq("rready_after_ar", 64'(ar_done), 64'(1));
                if (m_axi.rvalid && m_axi.rready) begin
                    r_cnt++; r_drop = 1; ar_done = 0;
                end

                // AW
                if (m_axi.awvalid) begin
                    if (!aw_seen) begin
                        aw_seen = 1; aw_wait = aw_dly; hold_aw = {m_axi.awprot, m_axi.awaddr};
                    end else
                        check_eq("aw_stable", 64'({m_axi.awprot, m_axi.awaddr}), 64'(hold_aw));
                    aw_hi++;
                    m_axi.awready = (aw_wait == 0);
                    if (aw_wait > 0) aw_wait--;
                    if (m_axi.awready) begin
                        aw_cnt++; aw_seen = 0; aw_done = 1;
                        cap_awaddr = m_axi.awaddr; cap_awprot = m_axi.awprot;
                        check_eq("aw_const", 64'({m_axi.awid, m_axi.awlen, m_axi.awsize,
                                                  m_axi.awburst}), 64'(AX_CONST));
                    end
                end else m_axi.awready = 1'b0;

                // W
                if (m_axi.wvalid) begin
                    if (!w_seen) begin
                        w_seen = 1; w_wait = w_dly; hold_w = {m_axi.wstrb, m_axi.wdata};
                    end else
                        check_eq("w_stable", 64'({m_axi.wstrb, m_axi.wdata}), 64'(hold_w));
                    w_hi++;
                    m_axi.wready = (w_wait == 0);
                    if (w_wait > 0) w_wait--;
                    if (m_axi.wready) begin
                        w_cnt++; w_seen = 0; w_done = 1;
                        cap_wdata = m_axi.wdata; cap_wstrb = m_axi.wstrb;
                        check_eq("wlast", 64'(m_axi.wlast), 64'(1));
                    end
                end else m_axi.wready = 1'b0;

                // AR
                if (m_axi.arvalid) begin
                    if (!ar_seen) begin
                        ar_seen = 1; ar_wait = ar_dly; hold_ar = {m_axi.arprot, m_axi.araddr};
                    end else
                        check_eq("ar_stable", 64'({m_axi.arprot, m_axi.araddr}), 64'(hold_ar));
                    m_axi.arready = (ar_wait == 0);
                    if (ar_wait > 0) ar_wait--;
                    if (m_axi.arready) begin
                        ar_cnt++; ar_total++; ar_seen = 0; ar_done = 1;
                        cap_araddr = m_axi.araddr; cap_arprot = m_axi.arprot;
                        check_eq("ar_const", 64'({m_axi.arid, m_axi.arlen, m_axi.arsize,
                                                  m_axi.arburst}), 64'(AX_CONST));
                    end
                end else m_axi.arready = 1'b0;
            end
        end
    end

    function automatic logic [63:0] pack_counts();
        return 64'({4'(aw_cnt), 4'(w_cnt), 4'(b_cnt), 4'(ar_cnt), 4'(r_cnt)});
    endfunction

    // One native transaction. hold keeps mem_valid high through completion;
    // no_wait drives the request immediately (used right after a held one).
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic instr,
                          input int d_aw, input int d_w, input int d_b,
                          input int d_ar, input int d_r, input logic [1:0] resp,
                          input bit hold, input bit no_wait, output int lat);
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
        int          idx;
        bit          got;
        bit          is_wr;
        is_wr     = (strb != 4'd0);
        idx       = int'(addr[7:2]);
        exp_addr  = {addr[31:2], 2'b00};
        exp_rdata = ref_mem[idx];
        if (!no_wait) @(negedge clk);
        aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
        cur_resp = resp;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; aw_hi = 0; w_hi = 0;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata;
        mem_wstrb = strb; mem_instr = instr;
        got = 0; lat = -1;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1; lat = c;
            end else begin
                // request is latched; the bridge must ignore these
                mem_addr = $urandom; mem_wdata = $urandom;
                mem_wstrb = 4'($urandom); mem_instr = 1'($urandom);
            end
        end
        check_eq("completion", 64'(got), 64'(1));
        if (got) begin
            check_eq("mem_err", 64'(mem_err), 64'(resp[1]));
            if (is_wr) begin
                check_eq("rdata_kept", 64'(mem_rdata), 64'(ref_last_rdata));
                check_eq("wr_counts", pack_counts(), 64'(20'h11100));
                check_eq("awaddr", 64'(cap_awaddr), 64'(exp_addr));
                check_eq("awprot", 64'(cap_awprot), 64'({instr, 2'b00}));
                check_eq("wdata", 64'(cap_wdata), 64'(wdata));
                check_eq("wstrb", 64'(cap_wstrb), 64'(strb));
            end else begin
                check_eq("rdata", 64'(mem_rdata), 64'(exp_rdata));
                check_eq("rd_counts", pack_counts(), 64'(20'h00011));
                check_eq("araddr", 64'(cap_araddr), 64'(exp_addr));
                check_eq("arprot", 64'(cap_arprot), 64'({instr, 2'b00}));
            end
            if (!hold) mem_valid = 1'b0;
            @(negedge clk);
            check_eq("ready_pulse", 64'(mem_ready), 64'(0));
            check_eq("err_clear", 64'(mem_err), 64'(0));
            if (is_wr && !resp[1]) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (!is_wr) ref_last_rdata = exp_rdata;
        end
    endtask

    function automatic logic [1:0] pick_resp();
        int r;
        r = $urandom_range(0, 5);
        if (r == 3) return 2'b01;
        if (r == 4) return 2'b10;
        if (r == 5) return 2'b11;
        return 2'b00;
    endfunction

    initial begin
        int          lat;
        int          ar_snap;
        bit          prev_hold;
        bit          hold;
        logic [3:0]  strb;
        logic [31:0] v;

        for (int i = 0; i < 64; i++) begin
            v = $urandom; slave_mem[i] = v; ref_mem[i] = v;
        end
        ref_last_rdata = 32'd0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_wstrb = 4'd0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; cur_resp = 2'b00;
        ar_total = 0;

        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", 64'(m_axi.awvalid), 64'(0));
        check_eq("rst_wvalid", 64'(m_axi.wvalid), 64'(0));
        check_eq("rst_arvalid", 64'(m_axi.arvalid), 64'(0));
        check_eq("rst_bready", 64'(m_axi.bready), 64'(0));
        check_eq("rst_rready", 64'(m_axi.rready), 64'(0));
        check_eq("rst_mem_ready", 64'(mem_ready), 64'(0));
        check_eq("rst_mem_err", 64'(mem_err), 64'(0));
        check_eq("rst_mem_rdata", 64'(mem_rdata), 64'(0));
        check_eq("rst_addr", 64'({m_axi.awaddr, m_axi.araddr}), 64'(0));
        check_eq("rst_wpayload", 64'({m_axi.wstrb, m_axi.wdata}), 64'(0));
        check_eq("rst_prot", 64'({m_axi.awprot, m_axi.arprot}), 64'(0));
        resetn = 1'b1;

        // Zero-wait read
        slave_mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
        do_txn(32'h0000_1004, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 0, 2'b00, 0, 0, lat);
        check_eq("rd_latency", 64'(lat), 64'(2));

        // Zero-wait write
        do_txn(32'h0000_0008, 32'hCAFE_F00D, 4'hF, 1'b0, 0, 0, 0, 0, 0, 2'b00, 0, 0, lat);
        check_eq("wr_latency_min", 64'(lat >= 2), 64'(1));

        // AW held 3 cycles, W immediate
        do_txn(32'h0000_2000, 32'h1234_5678, 4'b0011, 1'b0, 3, 0, 1, 0, 0, 2'b00, 0, 0, lat);
        check_eq("aw_high_cycles", 64'(aw_hi), 64'(4));
        check_eq("w_high_cycles", 64'(w_hi), 64'(1));

        // W delayed, AW immediate; then both accepted together
        do_txn(32'h0000_2000, 32'hA5A5_5A5A, 4'b1100, 1'b0, 0, 3, 0, 0, 0, 2'b00, 0, 0, lat);
        check_eq("w_delay_high", 64'({8'(aw_hi), 8'(w_hi)}), 64'(16'h0104));
        do_txn(32'h0000_2000, 32'h0F0F_F0F0, 4'b0110, 1'b0, 2, 2, 0, 0, 0, 2'b00, 0, 0, lat);
        check_eq("same_cycle_high", 64'({8'(aw_hi), 8'(w_hi)}), 64'(16'h0303));

        // Error responses
        do_txn(32'h0000_0010, 32'h1111_2222, 4'hF, 1'b0, 0, 0, 0, 0, 0, 2'b10, 0, 0, lat);
        do_txn(32'h0000_0010, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 2, 2'b11, 0, 0, lat);

        // Back-to-back instruction fetches with mem_valid held over completion
        ar_snap = ar_total;
        do_txn(32'h0000_0000, 32'd0, 4'd0, 1'b1, 0, 0, 0, 0, 0, 2'b00, 1, 0, lat);
        do_txn(32'h0000_0004, 32'd0, 4'd0, 1'b1, 0, 0, 0, 0, 0, 2'b00, 0, 1, lat);
        check_eq("fetch_ar_total", 64'(ar_total - ar_snap), 64'(2));

        // Reset in the middle of a write
        @(negedge clk);
        aw_dly = 6; w_dly = 6; b_dly = 0; cur_resp = 2'b00;
        mem_valid = 1'b1; mem_addr = 32'h0000_0040; mem_wdata = 32'h7777_7777;
        mem_wstrb = 4'hF; mem_instr = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_pre_awvalid", 64'(m_axi.awvalid), 64'(1));
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_mid_awvalid", 64'(m_axi.awvalid), 64'(0));
        check_eq("rst_mid_wvalid", 64'(m_axi.wvalid), 64'(0));
        check_eq("rst_mid_mem_ready", 64'(mem_ready), 64'(0));
        check_eq("rst_mid_rdata", 64'(mem_rdata), 64'(0));
        check_eq("rst_mid_awaddr", 64'(m_axi.awaddr), 64'(0));
        mem_valid = 1'b0;
        ref_last_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        do_txn(32'h0000_0044, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 0, 2'b00, 0, 0, lat);
        check_eq("post_rst_rd_latency", 64'(lat), 64'(2));

        // Randomized traffic
        prev_hold = 0;
        for (int t = 0; t < 40; t++) begin
            strb = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            hold = (t < 39) && ($urandom_range(0, 3) == 0);
            do_txn($urandom, $urandom, strb, 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), pick_resp(),
                   hold, prev_hold, lat);
            prev_hold = hold;
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/custom2axi.md
Name: custom2axi

Overview:
- Bridge from the PicoRV32-style native memory bus (mem_valid/mem_ready) to a full AXI4 master with separate AW/W/B/AR/R channels.
- Lets a native-bus CPU or DMA reach AXI slaves; the reverse of the existing AXI-to-native bridge.
- One outstanding single-beat 32-bit transaction at a time, with registered completion and an error flag.

Parameters:
- AXI_ID, 0, constant value driven on awid/arid.
- ALIGN_ADDR, 1, if 1 awaddr/araddr[1:0] are forced to 2'b00.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- mem_valid  in  1  native request valid
- mem_instr  in  1  request is an instruction fetch
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_err  out  1  completion carried SLVERR/DECERR, valid while mem_ready=1
- m_axi_awvalid/awready  out/in  1  AW handshake
- m_axi_awaddr  out  32 ; m_axi_awid out 4 ; m_axi_awlen out 8 ; m_axi_awsize out 3 ; m_axi_awburst out 2 ; m_axi_awprot out 3
- m_axi_wvalid/wready  out/in  1 ; m_axi_wdata out 32 ; m_axi_wstrb out 4 ; m_axi_wlast out 1
- m_axi_bvalid/bready  in/out  1 ; m_axi_bresp in 2 ; m_axi_bid in 4 (ignored)
- m_axi_arvalid/arready  out/in  1 ; m_axi_araddr out 32 ; m_axi_arid out 4 ; m_axi_arlen out 8 ; m_axi_arsize out 3 ; m_axi_arburst out 2 ; m_axi_arprot out 3
- m_axi_rvalid/rready  in/out  1 ; m_axi_rdata in 32 ; m_axi_rresp in 2 ; m_axi_rlast in 1 ; m_axi_rid in 4 (rlast/rid ignored)

Behaviour:
- Reset values: all valid/ready outputs 0, mem_ready 0, mem_err 0, mem_rdata 0, FSM in IDLE, latched address/data/strobe 0.
- Constant outputs: awlen/arlen=0, awsize/arsize=3'd2, awburst/arburst=2'b01, wlast=1, awid/arid=AXI_ID.
- awprot/arprot = {mem_instr latched, 2'b00}.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, DONE.
- IDLE: when mem_valid=1 and mem_ready=0, latch addr (aligned per ALIGN_ADDR), wdata, wstrb and instr.
  - wstrb!=0: go to WRITE, set awvalid=1 and wvalid=1 on the same edge.
  - wstrb==0: go to RADDR, set arvalid=1.
- WRITE: awvalid and wvalid drop independently on their own handshake.
  - Go to WRESP on the edge where both have completed, including both in the same cycle or in different cycles.
  - Payloads are held stable while valid is high.
- WRESP: bready=1 combinationally in this state only. On the bvalid&bready edge: mem_ready<=1, mem_err<=bresp[1], go to DONE.
- RADDR: arvalid held until arready. On the handshake, arvalid<=0 and go to RDATA.
- RDATA: rready=1 in this state only. On the rvalid&rready edge: mem_rdata<=rdata, mem_err<=rresp[1], mem_ready<=1, go to DONE.
- DONE: mem_ready=1 for exactly this cycle. Next edge: mem_ready<=0, mem_err<=0, go to IDLE.
  - mem_valid sampled in DONE is ignored, so the request just completed is never re-issued.
- mem_rdata holds its last read value; writes do not change it.
- Latency:
  - Read with zero-wait slave: request seen in IDLE; arvalid 1 cycle later; the R handshake can follow no earlier than the cycle after AR; mem_ready 1 cycle after R.
  - Write with zero-wait slave: mem_ready no earlier than 3 cycles after mem_valid.
- Changes to mem_* while a request is in flight are ignored, because all payloads come from latches.
- B or R valid arriving in a state that does not expect it: not accepted (ready=0), no effect.
- Reset mid-transaction: all outputs return to reset values asynchronously and the in-flight AXI transaction is abandoned. The system resets both sides together.

Test Plan:
- Read, zero-wait slave: mem_addr=0x0000_1004, wstrb=0, rdata=0xDEADBEEF, rresp=0 -> araddr=0x1004, arprot=0, arlen=0, arsize=2; one mem_ready pulse with rdata=0xDEADBEEF and mem_err=0.
- Write, awready delayed 3 cycles, wready immediate: addr=0x2000, wdata=0x12345678, wstrb=4'b0011 -> wvalid drops after 1 cycle, awvalid after 4 cycles; bready only after both; one mem_ready pulse; no duplicate AW or W.
- Write, wready delayed and AW/W accepted in the same cycle in a repeat run -> exactly one of each handshake; WRESP reached in both runs.
- Errors: bresp=2'b10, and separately rresp=2'b11 -> mem_err=1 coincident with mem_ready; mem_err=0 the following cycle.
- Instruction fetch back-to-back: mem_instr=1 read at 0x0, mem_valid held high across completion, then read at 0x4 -> arprot=3'b100; exactly two AR handshakes; the second issued from IDLE after DONE.
- Reset mid-write: resetn low while awvalid=1 -> awvalid, wvalid and mem_ready go 0 immediately; after release the FSM is in IDLE and a new read completes normally.
